crc_fcs_check: RTL

Downstream companion to `crc_byteEn_top`: compares every CRC the engine emits against the frame check sequence (FCS) received with that frame. The FCS extractor delivers each frame's received FCS before the pipelined CRC engine finishes. This block queues the FCS values in order and pairs each `crc_out_vld` pulse with the oldest queued FCS. It then reports a per-frame pass/fail, keeps saturating pass/fail counters, and holds sticky overflow/underflow flags for the status register block.

---
 rtl/crc_fcs_check.sv | 122 ++++++++++++
 1 files changed

// File: rtl/crc_fcs_check.sv
// crc_fcs_check: pairs each CRC emitted by the CRC engine with the oldest
// queued received FCS, reports per-frame pass/fail, keeps saturating
// pass/fail counters and sticky queue overflow/underflow flags.
module crc_fcs_check #(
    parameter int CRC_WIDTH  = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [CRC_WIDTH-1:0]          fcs_in,
    input  logic                          fcs_vld,
    input  logic [CRC_WIDTH-1:0]          crc_out,
    input  logic                          crc_out_vld,
    input  logic                          clr,
    output logic                          chk_vld,
    output logic                          chk_pass,
    output logic [CRC_WIDTH-1:0]          chk_crc,
    output logic [CRC_WIDTH-1:0]          chk_fcs,
    output logic [CNT_WIDTH-1:0]          pass_cnt,
    output logic [CNT_WIDTH-1:0]          fail_cnt,
    output logic                          ovf_err,
    output logic                          unf_err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [CRC_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW:0]          wptr;
    logic [AW:0]          rptr;

    logic                 empty;
    logic                 full;
    logic                 pop;
    logic                 bypass;
    logic                 underflow;
    logic                 push;
    logic                 overflow;
    logic [CRC_WIDTH-1:0] exp_fcs;
    logic                 pass_now;

    // Queue status and pairing decisions for the current cycle
    always_comb begin
        fifo_level = wptr - rptr;
        empty      = (fifo_level == '0);
        full       = (fifo_level == (AW+1)'(FIFO_DEPTH));
        pop        = crc_out_vld && !empty;
        bypass     = crc_out_vld && empty && fcs_vld;
        underflow  = crc_out_vld && empty && !fcs_vld;
        // A full queue still accepts a push when the head leaves this cycle
        push       = fcs_vld && !bypass && (!full || pop);
        overflow   = fcs_vld && full && !pop;
        exp_fcs    = '0;
        if (pop)
            exp_fcs = mem[rptr[AW-1:0]];
        else if (bypass)
            exp_fcs = fcs_in;
        pass_now   = !underflow && (crc_out == exp_fcs);
    end

    // FCS storage; contents need no reset since pointers gate every read
    always_ff @(posedge clk) begin
        if (push)
            mem[wptr[AW-1:0]] <= fcs_in;
    end

    // Queue pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
        end
    end

    // Registered per-frame result, one cycle after crc_out_vld
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_vld  <= 1'b0;
            chk_pass <= 1'b0;
            chk_crc  <= '0;
            chk_fcs  <= '0;
        end else begin
            chk_vld <= crc_out_vld;
            if (crc_out_vld) begin
                chk_pass <= pass_now;
                chk_crc  <= crc_out;
                chk_fcs  <= exp_fcs;
            end
        end
    end

    // Saturating counters and sticky flags; clr wins over any update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
            ovf_err  <= 1'b0;
            unf_err  <= 1'b0;
        end else if (clr) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
            ovf_err  <= 1'b0;
            unf_err  <= 1'b0;
        end else begin
            if (crc_out_vld && pass_now && (pass_cnt != '1))
                pass_cnt <= pass_cnt + CNT_WIDTH'(1);
            if (crc_out_vld && !pass_now && (fail_cnt != '1))
                fail_cnt <= fail_cnt + CNT_WIDTH'(1);
            if (overflow)
                ovf_err <= 1'b1;
            if (underflow)
                unf_err <= 1'b1;
        end
    end

endmodule
